// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported 64-bit data RAM.
// Optional macro DMEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins) instead of round-robin.
module dmem_arbiter #(
    parameter int unsigned  WAIT_CYCLES = 0,
    parameter logic [63:0]  ADDR_LIMIT  = 64'd258
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic        p0_write,
    input  logic [63:0] p0_addr,
    input  logic [63:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic [63:0] p0_rdata,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic        p1_write,
    input  logic [63:0] p1_addr,
    input  logic [63:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic [63:0] p1_rdata,
    output logic        p1_err,

    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        owner;
    logic        lat_write;
    logic [63:0] lat_addr;
    logic [63:0] lat_wdata;
    logic [3:0]  cnt;

    logic        any_req;
    logic        winner;
    logic        grant;
    logic        sel_write;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;
    logic        sel_illegal;

    logic        load_resp;
    logic        resp_port;
    logic [63:0] resp_rdata;
    logic        resp_err;

    assign any_req = p0_req | p1_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign winner = !p0_req;
`else
    // last_gnt == 1 means port 1 was served last, so port 0 is favoured.
    logic last_gnt;

    assign winner = (p0_req && p1_req) ? !last_gnt : !p0_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (grant) begin
            last_gnt <= winner;
        end
    end
`endif

    // Gating with rst keeps gnt low while reset is held, even if a req is already up.
    assign grant       = (state == IDLE) && any_req && !rst;
    assign sel_write   = winner ? p1_write : p0_write;
    assign sel_addr    = winner ? p1_addr  : p0_addr;
    assign sel_wdata   = winner ? p1_wdata : p0_wdata;
    assign sel_illegal = (sel_addr >= ADDR_LIMIT);

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        load_resp  = 1'b0;
        resp_port  = owner;
        resp_rdata = 64'd0;
        resp_err   = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    if (sel_illegal) begin
                        state_nx  = RESP;
                        load_resp = 1'b1;
                        resp_port = winner;
                        resp_err  = 1'b1;
                    end else begin
                        state_nx = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nx   = RESP;
                    load_resp  = 1'b1;
                    resp_rdata = lat_write ? 64'd0 : mem_rdata;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= 64'd0;
            lat_wdata <= 64'd0;
            cnt       <= 4'd0;
        end else begin
            if (grant) begin
                owner     <= winner;
                lat_write <= sel_write;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
                cnt       <= 4'(WAIT_CYCLES);
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Per-port response registers: only the owner's copy changes, the other holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rdata <= 64'd0;
            p0_err   <= 1'b0;
            p1_rdata <= 64'd0;
            p1_err   <= 1'b0;
        end else if (load_resp) begin
            if (resp_port) begin
                p1_rdata <= resp_rdata;
                p1_err   <= resp_err;
            end else begin
                p0_rdata <= resp_rdata;
                p0_err   <= resp_err;
            end
        end
    end

    // Strobes decode straight from the state register, so an async reset drops them at once.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 64'd0;
        mem_wdata = 64'd0;
        if (state == ACCESS) begin
            mem_read  = !lat_write;
            mem_write = lat_write;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
        end
    end

    assign p0_gnt  = grant && !winner;
    assign p1_gnt  = grant && winner;
    assign p0_done = (state == RESP) && !owner;
    assign p1_done = (state == RESP) && owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expectations pushed at grant, popped and compared at done.
module tb_dmem_arbiter;

    localparam int          W     = 3;
    localparam logic [63:0] LIMIT = 64'd258;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        p0_req, p0_write, p0_gnt, p0_done, p0_err;
    logic [63:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_write, p1_gnt, p1_done, p1_err;
    logic [63:0] p1_addr, p1_wdata, p1_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    dmem_arbiter #(.WAIT_CYCLES(W), .ADDR_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    // Second instance with zero wait states for the single-cycle access check.
    logic        a_req, a_write, a_gnt, a_done, a_err;
    logic [63:0] a_addr, a_wdata, a_rdata;
    logic        a1_req = 1'b0, a1_write = 1'b0;
    logic [63:0] a1_addr = 64'd0, a1_wdata = 64'd0;
    logic        a1_gnt, a1_done, a1_err;
    logic [63:0] a1_rdata;
    logic [63:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_read, a_mem_write;

    dmem_arbiter #(.WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst),
        .p0_req(a_req), .p0_write(a_write), .p0_addr(a_addr), .p0_wdata(a_wdata),
        .p0_gnt(a_gnt), .p0_done(a_done), .p0_rdata(a_rdata), .p0_err(a_err),
        .p1_req(a1_req), .p1_write(a1_write), .p1_addr(a1_addr), .p1_wdata(a1_wdata),
        .p1_gnt(a1_gnt), .p1_done(a1_done), .p1_rdata(a1_rdata), .p1_err(a1_err),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_read(a_mem_read),
        .mem_write(a_mem_write), .mem_rdata(a_mem_rdata)
    );

    logic [63:0] ram     [0:511];
    logic [63:0] ram0    [0:511];
    logic [63:0] ref_ram [0:511];

    assign mem_rdata   = (mem_addr < 64'd512)   ? ram[mem_addr[8:0]]    : 64'hBAD0_BAD0;
    assign a_mem_rdata = (a_mem_addr < 64'd512) ? ram0[a_mem_addr[8:0]] : 64'hBAD0_BAD0;

    always @(posedge clk) begin
        if (mem_write && mem_addr < 64'd512) ram[mem_addr[8:0]] <= mem_wdata;
        if (a_mem_write && a_mem_addr < 64'd512) ram0[a_mem_addr[8:0]] <= a_mem_wdata;
    end

    typedef struct {
        logic        port;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    logic gnt_log[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Grant monitor: build the expected response from the request seen at acceptance.
    always @(negedge clk) begin
        if (!rst && (p0_gnt || p1_gnt)) begin
            exp_t        e;
            logic [63:0] a;
            logic        w;
            if (p0_gnt && p1_gnt) check("dual_gnt", 1, 0);
            e.port  = p1_gnt;
            a       = e.port ? p1_addr : p0_addr;
            w       = e.port ? p1_write : p0_write;
            e.err   = (a >= LIMIT);
            e.rdata = (e.err || w) ? 64'd0 : ref_ram[a[8:0]];
            if (!e.err && w) ref_ram[a[8:0]] = e.port ? p1_wdata : p0_wdata;
            sb.push_back(e);
            gnt_log.push_back(e.port);
        end
    end

    // Done monitor: pop and compare.
    always @(negedge clk) begin
        if (!rst && (p0_done || p1_done)) begin
            exp_t e;
            if (p0_done && p1_done) check("dual_done", 1, 0);
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("done_port", p1_done, e.port);
                check("rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
                check("err", e.port ? p1_err : p0_err, e.err);
            end
        end
        if (mem_read && mem_write) check("dual_strobe", 1, 0);
    end

    task automatic drive(input logic port, input logic req, input logic wr,
                         input logic [63:0] addr, input logic [63:0] wd);
        if (port) begin
            p1_req = req; p1_write = wr; p1_addr = addr; p1_wdata = wd;
        end else begin
            p0_req = req; p0_write = wr; p0_addr = addr; p0_wdata = wd;
        end
    endtask

    // One transaction; req drops the cycle after gnt and the address is scrambled.
    task automatic txn(input logic port, input logic wr, input logic [63:0] addr,
                       input logic [63:0] wd, output int lat, output int strobes);
        int t0;
        bit got;
        lat     = -1;
        strobes = 0;
        @(posedge clk); #1;
        drive(port, 1'b1, wr, addr, wd);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (port ? p1_gnt : p0_gnt) got = 1;
        end
        if (!got) begin
            check("gnt_timeout", 0, 1);
            drive(port, 1'b0, 1'b0, 64'd0, 64'd0);
            return;
        end
        t0 = cyc;
        @(posedge clk); #1;
        drive(port, 1'b0, ~wr, ~addr, ~wd);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (mem_read || mem_write) strobes++;
            if (port ? p1_done : p0_done) got = 1;
        end
        if (!got) check("done_timeout", 0, 1);
        else lat = cyc - t0;
    endtask

    int lat, strobes, n;
    bit seen;

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        a_req = 1'b0; a_write = 1'b0; a_addr = 64'd0; a_wdata = 64'd0;
        for (int i = 0; i < 512; i++) begin
            ram[i]     = {32'hA5A5_0000, 32'(i * 3 + 7)};
            ref_ram[i] = {32'hA5A5_0000, 32'(i * 3 + 7)};
            ram0[i]    = 64'd0;
        end
        ram0[5] = 64'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        #1;
        check("rst_p0_gnt", p0_gnt, 0);
        check("rst_done", {p0_done, p1_done}, 0);
        check("rst_strobes", {mem_read, mem_write}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rdata", p0_rdata | p1_rdata, 0);
        check("rst_err", {p0_err, p1_err}, 0);
        rst = 1'b0;

        // Zero wait states: gnt cycle 0, read strobe cycle 1 only, done cycle 2.
        @(posedge clk); #1;
        a_req = 1'b1; a_addr = 64'd5;
        @(negedge clk);
        check("w0_gnt", a_gnt, 1);
        check("w0_c0_read", a_mem_read, 0);
        @(posedge clk); #1;
        a_req = 1'b0; a_addr = 64'd9;
        @(negedge clk);
        check("w0_c1_read", a_mem_read, 1);
        check("w0_c1_done", a_done, 0);
        @(negedge clk);
        check("w0_c2_read", a_mem_read, 0);
        check("w0_c2_done", a_done, 1);
        check("w0_rdata", a_rdata, 64'hDEAD_BEEF);
        check("w0_err", a_err, 0);
        @(negedge clk);
        check("w0_done_pulse", a_done, 0);

        txn(1'b1, 1'b1, 64'd10, 64'h1234, lat, strobes);
        check("wr_latency", lat, W + 2);
        check("wr_strobes", strobes, W + 1);
        txn(1'b1, 1'b0, 64'd10, 64'd0, lat, strobes);
        check("rd_latency", lat, W + 2);
        check("rd_value", p1_rdata, 64'h1234);

        txn(1'b0, 1'b0, LIMIT, 64'd0, lat, strobes);
        check("err_latency", lat, 1);
        check("err_strobes", strobes, 0);
        txn(1'b0, 1'b0, LIMIT - 64'd1, 64'd0, lat, strobes);
        check("edge_latency", lat, W + 2);
        txn(1'b0, 1'b0, 64'h1_0000_0005, 64'd0, lat, strobes);
        check("hi_addr_latency", lat, 1);
        txn(1'b0, 1'b1, 64'd20, 64'hCAFE_F00D_0000_0001, lat, strobes);
        txn(1'b0, 1'b0, 64'd20, 64'd0, lat, strobes);

        // req dropped after gnt: no second grant afterwards.
        n = gnt_log.size();
        txn(1'b1, 1'b0, 64'd7, 64'd0, lat, strobes);
        check("drop_done_latency", lat, W + 2);
        repeat (8) @(negedge clk);
        check("no_regrant", gnt_log.size(), n + 1);

        // Reset during ACCESS of a write.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 64'd30, 64'h5555);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (p0_gnt) seen = 1;
        end
        if (!seen) check("rst_test_gnt_timeout", 0, 1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        check("pre_rst_write", mem_write, 1);
        #2 rst = 1'b1;
        #1 check("rst_drops_write", mem_write, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (p0_done || p1_done) seen = 1;
        end
        check("rst_no_done", seen, 0);

        // Contention straight after reset.
        gnt_log.delete();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 64'd3, 64'd0);
        drive(1'b1, 1'b1, 1'b0, 64'd4, 64'd0);
        for (int i = 0; i < 200 && gnt_log.size() < 6; i++) @(negedge clk);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        check("contention_grants", gnt_log.size(), 6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            check($sformatf("fixed_gnt%0d", i), gnt_log[i], 0);
`else
            check($sformatf("rr_gnt%0d", i), gnt_log[i], i % 2);
`endif
        end
        repeat (12) @(negedge clk);

        txn(1'b1, 1'b0, 64'd11, 64'd0, lat, strobes);
        check("post_rst_p1_latency", lat, W + 2);
        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
